// File: rtl/world_clock_pkg.sv
// Shared encodings and wrap-around helpers for the world-clock controller.
// Optional build macro used by the top: WORLD_CLOCK_AUTO_ROTATE_EN.
package world_clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [1:0] TZ_KOREA   = 2'd0;
    localparam logic [1:0] TZ_PARIS   = 2'd1;
    localparam logic [1:0] TZ_NEWYORK = 2'd2;
    localparam logic [1:0] TZ_UK      = 2'd3;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // Terminal value is checked before incrementing, so nothing out of range is ever produced.
    function automatic logic [4:0] hour_inc(input logic [4:0] v);
        return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] minsec_inc(input logic [5:0] v);
        return (v == MINSEC_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [1:0] tz_inc(input logic [1:0] v);
        return (v == TZ_UK) ? TZ_KOREA : v + 2'd1;
    endfunction

endpackage

// File: rtl/world_clock_ctrl_tick_divider.sv
// Free-running clk divider producing a registered one-cycle tick every TICK_DIV cycles.
// The tick is high exactly while the count sits at TICK_DIV-1; clr restarts the count at 0.
module tick_divider #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Registered decode of the next count keeps tick aligned with the count value.
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/world_clock_ctrl.sv
// Master KST timekeeper, set-time mode FSM and displayed-timezone selector.
// Define WORLD_CLOCK_AUTO_ROTATE_EN to advance tz_sel automatically every ROTATE_SEC seconds in RUN.
module world_clock_ctrl
    import world_clock_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ROTATE_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_next,
    output logic [4:0] hour_kst,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] tz_sel,
    output logic [1:0] mode,
    output logic       sec_pulse
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("world_clock_ctrl: TICK_DIV must be at least 2");
    end
    if (ROTATE_SEC < 1 || ROTATE_SEC > 63) begin : g_bad_rotate_sec
        $error("world_clock_ctrl: ROTATE_SEC must be in 1..63");
    end

    mode_e      state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [1:0] tz_q, tz_d;
    logic       tick;
    logic       in_run;
    logic       edit_exit;

    assign in_run    = (state_q == MODE_RUN);
    assign edit_exit = (state_q == MODE_SET_MIN) && btn_mode;

    // Leaving SET_MIN restarts the second so the edited minute begins on a full second.
    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk (clk),
        .rst (rst),
        .clr (edit_exit),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                MODE_RUN:      state_d = MODE_SET_HOUR;
                MODE_SET_HOUR: state_d = MODE_SET_MIN;
                MODE_SET_MIN:  state_d = MODE_RUN;
                default:       state_d = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        mode = state_q;
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        case (state_q)
            MODE_RUN: begin
                if (tick) begin
                    sec_d = minsec_inc(sec_q);
                    if (sec_q == MINSEC_MAX) begin
                        min_d = minsec_inc(min_q);
                        if (min_q == MINSEC_MAX) begin
                            hour_d = hour_inc(hour_q);
                        end
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (btn_up && !btn_mode) begin
                    hour_d = hour_inc(hour_q);
                end
            end
            MODE_SET_MIN: begin
                if (btn_mode) begin
                    sec_d = 6'd0;
                end else if (btn_up) begin
                    min_d = minsec_inc(min_q);
                end
            end
            default: ;
        endcase
    end

`ifdef WORLD_CLOCK_AUTO_ROTATE_EN
    localparam logic [5:0] ROT_LAST = 6'(ROTATE_SEC - 1);

    logic [5:0] rot_q, rot_d;
    logic       auto_adv;

    assign auto_adv = in_run && tick && (rot_q == ROT_LAST);

    // A manual and an automatic advance in the same cycle collapse into one step.
    always_comb begin
        rot_d = rot_q;
        tz_d  = tz_q;
        if ((in_run && btn_next) || auto_adv) begin
            tz_d = tz_inc(tz_q);
        end
        if (edit_exit) begin
            rot_d = 6'd0;
        end else if (in_run) begin
            if (btn_next || auto_adv) begin
                rot_d = 6'd0;
            end else if (tick) begin
                rot_d = rot_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_q <= 6'd0;
        end else begin
            rot_q <= rot_d;
        end
    end
`else
    always_comb begin
        tz_d = tz_q;
        if (in_run && btn_next) begin
            tz_d = tz_inc(tz_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q <= 5'd0;
            min_q  <= 6'd0;
            sec_q  <= 6'd0;
            tz_q   <= TZ_KOREA;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            tz_q   <= tz_d;
        end
    end

    assign hour_kst  = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign tz_sel    = tz_q;
    assign sec_pulse = tick;

endmodule

// File: tb/tb_world_clock_ctrl.sv
// Directed bench for world_clock_ctrl with TICK_DIV=4 and ROTATE_SEC=2.
// Auto-rotate checks are built only when WORLD_CLOCK_AUTO_ROTATE_EN is defined.
module tb_world_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_next = 1'b0;
    logic [4:0] hour_kst;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] tz_sel;
    logic [1:0] mode;
    logic       sec_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    world_clock_ctrl #(
        .TICK_DIV  (4),
        .ROTATE_SEC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_next (btn_next),
        .hour_kst (hour_kst),
        .minute   (minute),
        .second   (second),
        .tz_sel   (tz_sel),
        .mode     (mode),
        .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_up(input int n);
        repeat (n) begin
            btn_up = 1'b1;
            step(1);
            btn_up = 1'b0;
        end
    endtask

    task automatic pulse_next();
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, 32'(hour_kst), 32'(h));
        check({tag, "_min"},  32'(minute),   32'(m));
        check({tag, "_sec"},  32'(second),   32'(s));
    endtask

    initial begin
        // Reset state
        step(2);
        check_time("reset", 0, 0, 0);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_tz", 32'(tz_sel), 32'd0);
        check("reset_pulse", 32'(sec_pulse), 32'd0);
        rst = 1'b0;

        // Idle 12 cycles: strobes after edges 3, 7, 11
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("idle_pulse_%0d", k), 32'(sec_pulse), (k % 4 == 3) ? 32'd1 : 32'd0);
        end
        check_time("idle12", 0, 0, 3);
        check("idle12_mode", 32'(mode), 32'd0);
        check("idle12_tz", 32'(tz_sel), 32'd0);

        // Set hour: wrap 23 -> 0 without touching the minute
        pulse_mode();
        check("set_hour_mode", 32'(mode), 32'd1);
        pulse_up(23);
        check("hour_23", 32'(hour_kst), 32'd23);
        pulse_up(1);
        check("hour_wrap", 32'(hour_kst), 32'd0);
        check("hour_wrap_min", 32'(minute), 32'd0);
        pulse_up(23);
        check("hour_23_again", 32'(hour_kst), 32'd23);

        // btn_mode wins over btn_up
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        step(1);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        check("prio_mode", 32'(mode), 32'd2);
        check("prio_hour", 32'(hour_kst), 32'd23);
        check("prio_min", 32'(minute), 32'd0);

        // Set minute: wrap 59 -> 0 with no carry, time frozen
        pulse_up(59);
        check("min_59", 32'(minute), 32'd59);
        pulse_up(1);
        check("min_wrap", 32'(minute), 32'd0);
        check("min_wrap_hour", 32'(hour_kst), 32'd23);
        pulse_up(59);
        check_time("set_frozen", 23, 59, 3);

        // Exit to RUN clears second and divider
        pulse_mode();
        check("exit_mode", 32'(mode), 32'd0);
        check_time("exit", 23, 59, 0);
        check("exit_pulse", 32'(sec_pulse), 32'd0);
        step(3);
        check("exit_first_pulse", 32'(sec_pulse), 32'd1);
        step(233);
        check_time("edge236", 23, 59, 59);
        step(3);
        check_time("edge239", 23, 59, 59);
        check("edge239_pulse", 32'(sec_pulse), 32'd1);

        // Midnight rollover with btn_next on the same edge
        pulse_next();
        check_time("rollover", 0, 0, 0);
`ifndef WORLD_CLOCK_AUTO_ROTATE_EN
        check("rollover_tz", 32'(tz_sel), 32'd1);
        pulse_next();
        check("tz_2", 32'(tz_sel), 32'd2);
        pulse_next();
        check("tz_3", 32'(tz_sel), 32'd3);
        pulse_next();
        check("tz_wrap", 32'(tz_sel), 32'd0);
`endif

        // btn_up ignored in RUN
        pulse_up(1);
        check("run_up_hour", 32'(hour_kst), 32'd0);
        check("run_up_min", 32'(minute), 32'd0);
        check("run_up_mode", 32'(mode), 32'd0);

        // Reset mid-edit discards the edit
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pulse_mode();
        pulse_up(7);
        pulse_mode();
        pulse_up(3);
        pulse_next();
        check("setmin_tz_hold", 32'(tz_sel), 32'd0);
        check("setmin_mode", 32'(mode), 32'd2);
        check("setmin_hour", 32'(hour_kst), 32'd7);
        check("setmin_min", 32'(minute), 32'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_time("rst_edit", 0, 0, 0);
        check("rst_edit_mode", 32'(mode), 32'd0);
        check("rst_edit_tz", 32'(tz_sel), 32'd0);
        check("rst_edit_pulse", 32'(sec_pulse), 32'd0);

`ifdef WORLD_CLOCK_AUTO_ROTATE_EN
        // Auto advance every 2 s: seconds tick at edges 4, 8, 12, ...
        step(7);
        check("rot_e7", 32'(tz_sel), 32'd0);
        step(1);
        check("rot_e8", 32'(tz_sel), 32'd1);
        step(7);
        check("rot_e15", 32'(tz_sel), 32'd1);
        step(1);
        check("rot_e16", 32'(tz_sel), 32'd2);
        step(7);
        pulse_next();
        check("rot_coincide", 32'(tz_sel), 32'd3);
        step(7);
        check("rot_e31", 32'(tz_sel), 32'd3);
        step(1);
        check("rot_e32", 32'(tz_sel), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/world_clock_ctrl.md
Name: world_clock_ctrl

Overview:
- Sequencer and configuration controller for the world-clock datapath.
- Keeps the master KST time of day (hour/min/sec) from a divided 1 Hz tick.
- Runs a set-time mode FSM driven by button pulses.
- Selects the displayed timezone. hour_kst and tz_sel feed the combinational timezone converter at top level.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per second. Legal range is 2 or more.
- ROTATE_SEC, 5: seconds between automatic timezone advances. Used only with the optional feature. Legal range is 1 to 63.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse (already debounced); advances the mode FSM
- btn_up  in  1  one-cycle pulse; increments the field being edited
- btn_next  in  1  one-cycle pulse; advances tz_sel in RUN
- hour_kst  out  5  KST hour, 0..23
- minute  out  6  minute, 0..59
- second  out  6  second, 0..59
- tz_sel  out  2  0=Korea, 1=Paris, 2=New York, 3=UK
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
- sec_pulse  out  1  one-cycle strobe per elapsed second

Behaviour:
- Reset:
  - Clock and reset: one clock, clk; reset is synchronous and active-high on rst. rst is sampled on the clk rising edge.
  - On reset: hour_kst=0, minute=0, second=0, tz_sel=0, mode=RUN, sec_pulse=0, divider=0, rotate counter=0.
  - Reset asserted mid-edit returns to RUN and discards the edit.
- All outputs are registered. A change caused by an input at edge N is visible after edge N.
- Divider:
  - Counts 0..TICK_DIV-1 in every mode.
  - sec_pulse=1 for exactly the cycle in which the divider equals TICK_DIV-1. The divider then wraps to 0.
- RUN state:
  - On sec_pulse, second increments. 59 wraps to 0 and carries to minute.
  - minute 59 wraps to 0 and carries to hour_kst.
  - hour_kst 23 wraps to 0.
  - So 23:59:59 becomes 00:00:00 on one edge.
- SET_HOUR and SET_MIN states:
  - Timekeeping is frozen; sec_pulse is still generated.
  - btn_up increments the edited field only, with no carry: hour 23 wraps to 0, minute 59 wraps to 0.
- FSM transitions (on btn_mode):
  - RUN to SET_HOUR.
  - SET_HOUR to SET_MIN.
  - SET_MIN to RUN. On this exit, second is cleared to 0 and the divider is cleared to 0.
  - Any other input leaves the state unchanged.
- Priority:
  - btn_mode takes precedence over btn_up in the same cycle. btn_up is ignored that cycle.
  - btn_up in RUN is ignored.
- Timezone:
  - In RUN, btn_next sets tz_sel to tz_sel+1, modulo 4 (3 wraps to 0).
  - btn_next in the SET states is ignored.
  - btn_next and a sec_pulse carry in the same cycle both take effect.
- Arithmetic: all increments compare against the terminal value before incrementing. No out-of-range value is ever stored.

Optional Feature:
- Macro: WORLD_CLOCK_AUTO_ROTATE_EN.
- Defined:
  - A 6-bit rotate counter counts sec_pulse events in RUN.
  - When it reaches ROTATE_SEC-1 and sec_pulse occurs, tz_sel advances by 1 (mod 4) and the counter clears.
  - btn_next also clears the counter.
  - If btn_next and an auto-advance coincide, tz_sel advances once only.
  - The counter holds in the SET states and clears on entry to RUN.
- Not defined: no rotate counter exists, and tz_sel changes only on btn_next.

Decomposition:
- Package world_clock_pkg holds:
  - Mode encodings MODE_RUN=0, MODE_SET_HOUR=1, MODE_SET_MIN=2.
  - TZ codes TZ_KOREA=0, TZ_PARIS=1, TZ_NEWYORK=2, TZ_UK=3.
  - Constants HOUR_MAX=23 and MINSEC_MAX=59.
- One sub-module: tick_divider, parameterised by TICK_DIV, with ports clk, rst, clr, tick.

Test Plan (TICK_DIV=4 unless stated):
- Reset then idle 12 cycles -> exactly 3 sec_pulse strobes, spaced 4 cycles apart; second=3, mode=0, tz_sel=0.
- Set time to 23:59 via mode/up pulses, btn_mode back to RUN, wait 60 pulses -> at the 60th edge 23:59:59 becomes 00:00:00 on a single edge.
- In SET_HOUR at hour 23, btn_up -> hour 0 and minute unchanged. btn_mode+btn_up in the same cycle -> mode=SET_MIN with no increment.
- In RUN with tz_sel=3, btn_next -> tz_sel=0. btn_next in SET_MIN -> tz_sel unchanged.
- rst asserted while in SET_MIN with hour 7 -> next cycle all time outputs are 0 and mode=RUN.
- With WORLD_CLOCK_AUTO_ROTATE_EN and ROTATE_SEC=2: tz_sel goes 0 to 1 to 2 every 2 seconds. btn_next coincident with an auto-advance -> single increment.
